// File: rtl/piso_pkg.sv
`default_nettype none
// ============================================================================
// Package     : piso_pkg
// Description : Shared types and defaults for the parallel-in serial-out
//               transmitter and its bit counter.
// Revision    : 1.0 - initial release
// ============================================================================
package piso_pkg;

  // Two-state transmit FSM: waiting for a word, or shifting one out.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  localparam int PISO_DEFAULT_WIDTH = 8;

endpackage : piso_pkg
`default_nettype wire

// File: rtl/piso_bit_counter.sv
`default_nettype none
// ============================================================================
// Module      : piso_bit_counter
// Description : Synchronous-reset up-counter tracking the bit position within
//               the word being transmitted. Flags the final bit position.
// Ports       : clk    - clock, rising edge
//               rst    - synchronous active-high reset
//               clear  - force count to zero on the next edge
//               enable - advance count by one on the next edge
//               count  - current bit position
//               last   - high when count equals WIDTH-1
// Revision    : 1.0 - initial release
// ============================================================================
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int WIDTH = PISO_DEFAULT_WIDTH,
  parameter int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign last = (count == LAST_COUNT);

endmodule : piso_bit_counter
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module      : piso_serializer
// Description : Parallel-in serial-out transmitter. Accepts words over a
//               valid/ready handshake and launches one bit per rising edge,
//               back-to-back with no idle gap when the next word is offered
//               during the last bit of the current one.
// Ports       : clk        - clock, rising edge
//               rst        - synchronous active-high reset
//               data_in    - word to transmit, sampled on accept
//               load_valid - data_in is offered
//               load_ready - combinational: a word is accepted this edge
//               ser_out    - registered serial bit
//               frame      - registered: ser_out carries a valid bit
//               done       - registered: last bit of the word is on ser_out
// Revision    : 1.0 - initial release
// ============================================================================
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = PISO_DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             frame,
  output logic             done
);

  localparam int         CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [0:0] S_IDLE  = 1'(IDLE);
  localparam logic [0:0] S_SHIFT = 1'(SHIFT);

  logic [0:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;
  logic [CNT_W-1:0] count;
  logic             last;
  logic             accept;
  logic             shifting;
  logic             first_bit;
  logic             next_bit;

  // Bit-order selection: the shift register always presents the bit
  // currently on ser_out at its "head" end.
  if (MSB_FIRST) begin : g_msb_first
    assign shreg_next = shreg << 1;
    assign first_bit  = data_in[WIDTH-1];
    assign next_bit   = shreg_next[WIDTH-1];
  end else begin : g_lsb_first
    assign shreg_next = shreg >> 1;
    assign first_bit  = data_in[0];
    assign next_bit   = shreg_next[0];
  end

  // Ready during idle, or while the last bit is on the line so the next
  // word follows without a gap.
  assign load_ready = (state == S_IDLE) || last;
  assign accept     = load_valid && load_ready;
  assign shifting   = (state == S_SHIFT) && !last;

  piso_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk    (clk),
    .rst    (rst),
    .clear  (!shifting),
    .enable (shifting),
    .count  (count),
    .last   (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      shreg   <= '0;
      ser_out <= 1'b0;
      frame   <= 1'b0;
      done    <= 1'b0;
    end else if (accept) begin
      state   <= S_SHIFT;
      shreg   <= data_in;
      ser_out <= first_bit;
      frame   <= 1'b1;
      // A one-bit word is already on its last bit.
      done    <= (WIDTH == 1);
    end else if (shifting) begin
      shreg   <= shreg_next;
      ser_out <= next_bit;
      // The bit about to be shown is the last one.
      done    <= (int'(count) == WIDTH - 2);
    end else begin
      state   <= S_IDLE;
      shreg   <= '0;
      ser_out <= 1'b0;
      frame   <= 1'b0;
      done    <= 1'b0;
    end
  end

endmodule : piso_serializer
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_serializer
// Description : Self-checking bench for piso_serializer. Three instances
//               (8-bit MSB-first, 8-bit LSB-first, 1-bit) are exercised one
//               at a time against a queue-of-bits reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] d8a, d8b;
  logic       d1;
  logic       va, vb, vc;
  logic       ra, sa, fa, da;
  logic       rb, sb, fb, db;
  logic       rc, sc, fc, dc;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .data_in(d8a), .load_valid(va),
    .load_ready(ra), .ser_out(sa), .frame(fa), .done(da));

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .data_in(d8b), .load_valid(vb),
    .load_ready(rb), .ser_out(sb), .frame(fb), .done(db));

  piso_serializer #(.WIDTH(1), .MSB_FIRST(1'b1)) u_w1 (
    .clk(clk), .rst(rst), .data_in(d1), .load_valid(vc),
    .load_ready(rc), .ser_out(sc), .frame(fc), .done(dc));

  int errors = 0;
  int checks = 0;

  // Reference model: bits still to appear on the line, head = visible bit.
  bit q[$];
  int sel = 0;
  int cur_w = 8;
  bit cur_msb = 1'b1;
  int dut_accepts = 0;

  logic rdy_s, ser_s, frm_s, don_s;
  always_comb begin
    rdy_s = ra; ser_s = sa; frm_s = fa; don_s = da;
    case (sel)
      1: begin rdy_s = rb; ser_s = sb; frm_s = fb; don_s = db; end
      2: begin rdy_s = rc; ser_s = sc; frm_s = fc; don_s = dc; end
      default: ;
    endcase
  end

  task automatic drive(input bit v, input logic [7:0] data);
    va  = (sel == 0) && v;
    vb  = (sel == 1) && v;
    vc  = (sel == 2) && v;
    d8a = data;
    d8b = data;
    d1  = data[0];
  endtask

  task automatic select(input int s);
    sel     = s;
    cur_w   = (s == 2) ? 1 : 8;
    cur_msb = (s != 1);
  endtask

  // One clock cycle: check ready, clock, update model, check outputs.
  task automatic cycle(input bit v, input logic [7:0] data, output bit acc);
    bit exp_ready;
    drive(v, data);
    #1;
    exp_ready = (q.size() <= 1);
    checks++;
    if (rdy_s !== exp_ready) begin
      errors++;
      $display("FAIL load_ready dut%0d: got %b want %b", sel, rdy_s, exp_ready);
    end
    acc = v && exp_ready;
    if (v && rdy_s === 1'b1) dut_accepts++;
    @(posedge clk);
    if (acc) begin
      q.delete();
      for (int i = 0; i < cur_w; i++)
        q.push_back(data[cur_msb ? (cur_w - 1 - i) : i]);
    end else if (q.size() > 0) begin
      void'(q.pop_front());
    end
    #1;
    checks++;
    if (ser_s !== ((q.size() > 0) ? q[0] : 1'b0)) begin
      errors++;
      $display("FAIL ser_out dut%0d: got %b want %b", sel, ser_s,
               (q.size() > 0) ? q[0] : 1'b0);
    end
    checks++;
    if (frm_s !== (q.size() > 0)) begin
      errors++;
      $display("FAIL frame dut%0d: got %b want %b", sel, frm_s, q.size() > 0);
    end
    checks++;
    if (don_s !== (q.size() == 1)) begin
      errors++;
      $display("FAIL done dut%0d: got %b want %b", sel, don_s, q.size() == 1);
    end
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, acc);
  endtask

  // Reset with a word offered at the same edge: reset must win.
  task automatic do_reset(input bit v, input logic [7:0] data);
    drive(v, data);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 8'h00);
    q.delete();
    #1;
    checks++;
    if ({fa, sa, da, fb, sb, db, fc, sc, dc} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 000000000",
               {fa, sa, da, fb, sb, db, fc, sc, dc});
    end
    checks++;
    if ({ra, rb, rc} !== 3'b111) begin
      errors++;
      $display("FAIL reset_ready: got %b want 111", {ra, rb, rc});
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    select(0);
    do_reset(1'b0, 8'h00);
    idle_cycles(2);
  endtask

  task automatic test_msb_a5();
    bit acc;
    logic [7:0] seen;
    select(0);
    cycle(1'b1, 8'hA5, acc);
    seen[7] = sa;
    for (int i = 6; i >= 0; i--) begin
      cycle(1'b0, 8'h00, acc);
      seen[i] = sa;
    end
    checks++;
    if (seen !== 8'hA5) begin
      errors++;
      $display("FAIL msb_a5_sequence: got %h want a5", seen);
    end
    idle_cycles(2);
  endtask

  task automatic test_lsb_01();
    bit acc;
    select(1);
    cycle(1'b1, 8'h01, acc);
    idle_cycles(9);
  endtask

  task automatic test_back_to_back();
    logic [7:0] w[2] = '{8'hA5, 8'h3C};
    int idx = 0, frame_hi = 0, first_f = -1, last_f = -1, n = 0;
    bit acc;
    select(0);
    dut_accepts = 0;
    while ((idx < 2 || q.size() > 0) && n < 40) begin
      cycle(idx < 2, (idx < 2) ? w[idx] : 8'h00, acc);
      if (acc) idx++;
      if (fa === 1'b1) begin
        frame_hi++;
        if (first_f < 0) first_f = n;
        last_f = n;
      end
      n++;
    end
    checks++;
    if (frame_hi != 16 || last_f - first_f + 1 != 16) begin
      errors++;
      $display("FAIL b2b_frame: got %0d high over span %0d want 16", frame_hi,
               last_f - first_f + 1);
    end
    checks++;
    if (dut_accepts != 2) begin
      errors++;
      $display("FAIL b2b_accepts: got %0d want 2", dut_accepts);
    end
    idle_cycles(2);
  endtask

  task automatic test_hold_off();
    bit acc;
    int waits = 0;
    select(0);
    cycle(1'b1, 8'h00, acc);
    idle_cycles(3);
    acc = 1'b0;
    while (!acc && waits < 20) begin
      cycle(1'b1, 8'hFF, acc);
      waits++;
    end
    checks++;
    if (waits != 5) begin
      errors++;
      $display("FAIL hold_off_accept: got %0d offered cycles want 5", waits);
    end
    idle_cycles(9);
  endtask

  task automatic test_reset_mid();
    bit acc;
    select(0);
    cycle(1'b1, 8'hA5, acc);
    idle_cycles(2);
    do_reset(1'b1, 8'h3C);
    cycle(1'b1, 8'h3C, acc);
    idle_cycles(9);
  endtask

  task automatic test_width1();
    bit acc;
    select(2);
    for (int i = 0; i < 8; i++) cycle(1'b1, {7'b0, ~i[0]}, acc);
    idle_cycles(2);
  endtask

  task automatic test_random(input int s);
    bit acc, pending = 1'b0;
    logic [7:0] word = 8'h00;
    int n = 0;
    select(s);
    for (int i = 0; i < 250; i++) begin
      if (!pending && ($urandom % 3) != 0) begin
        pending = 1'b1;
        word    = 8'($urandom);
      end
      cycle(pending, word, acc);
      if (acc) pending = 1'b0;
    end
    while (pending && n < 20) begin
      cycle(1'b1, word, acc);
      if (acc) pending = 1'b0;
      n++;
    end
    idle_cycles(10);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_msb_a5();
    test_lsb_01();
    test_back_to_back();
    test_hold_off();
    test_reset_mid();
    test_width1();
    test_random(0);
    test_random(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_piso_serializer
`default_nettype wire

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out transmitter that launches one bit per rising clock edge onto a single serial line. It is the driving end of the single-bit sampling path: downstream rising-edge D flip-flops and shift chains capture `ser_out` on their `clk`. Upstream logic hands it words through a valid/ready handshake. Words are shifted out back-to-back with no idle gap whenever the next word is already offered.

## Interface
- `WIDTH`, default 8: bits per word; legal range ≥ 1.
- `MSB_FIRST`, default 1: 1 transmits bit `WIDTH-1` first; 0 transmits bit 0 first.

- `clk` input, 1 bit: single clock. All state updates on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `data_in` input, `WIDTH` bits: word to transmit; sampled only on an accepting edge.
- `load_valid` input, 1 bit: `data_in` is offered.
- `load_ready` output, 1 bit: block accepts a word on this edge.
- `ser_out` output, 1 bit: registered serial data bit.
- `frame` output, 1 bit: registered; high while `ser_out` carries a valid data bit.
- `done` output, 1 bit: registered one-cycle pulse, high during the last bit of each word.

## Operation
- FSM states: `IDLE` and `SHIFT`.
- Accept condition: `load_valid && load_ready` at a rising edge.
- `load_ready` is combinational and depends only on state:
  - high in `IDLE`;
  - high in `SHIFT` when the bit counter equals `WIDTH-1` (last bit);
  - low otherwise.
- `IDLE`:
  - Outputs: `ser_out`=0, `frame`=0, `done`=0.
  - On accept: load the shift register with `data_in`, clear the counter, and move to `SHIFT`.
- `SHIFT`:
  - `ser_out` shows the current bit selected by `MSB_FIRST`; `frame`=1.
  - Each edge: shift one position and increment the counter.
- Last bit (counter = `WIDTH-1`): `done`=1. At the following edge:
  - accept → reload the shift register, clear the counter, stay in `SHIFT`; no gap in `frame`.
  - no accept → return to `IDLE`.
- `load_valid` is ignored while `load_ready`=0. The producer holds `data_in` and `load_valid` until it is accepted.
- `WIDTH`=1: every `SHIFT` cycle is the last bit. `load_ready` stays high throughout `SHIFT`.
- Counter width is `max(1, $clog2(WIDTH))`. It never exceeds `WIDTH-1`; there is no wrap-around beyond reload.
- Reset (`rst`=1 at an edge), from any state including mid-word:
  - go to `IDLE`;
  - `ser_out`, `frame`, `done` = 0;
  - counter and shift register = 0;
  - any word in flight is discarded.
- `rst` takes priority over a simultaneous accept.

## Timing
- Word accepted at edge k: bit 0 of the transmit order is visible from just after edge k through edge k+1.
- Bit i is valid in the cycle following edge k+i. The last bit is valid after edge k+WIDTH-1.
- `frame` is high for exactly `WIDTH` cycles per word.
- Throughput: one word every `WIDTH` cycles when `load_valid` is held continuously.
- `ser_out` is stable across each full cycle, so a receiver clocked on `clk` captures bit i at edge k+i+1.
- First cycle after reset release: `load_ready`=1, all registered outputs 0.

## Structure
- Shared package `piso_pkg` holds:
  - `typedef enum logic [0:0] {IDLE, SHIFT} piso_state_t`;
  - `localparam int PISO_DEFAULT_WIDTH = 8`.
- One natural sub-module: `piso_bit_counter`. It is a synchronous-reset up-counter with a clear input and a `last` flag at `WIDTH-1`, instantiated once. The FSM, shift register and output registers stay in the top module.

## Test plan
- `WIDTH`=8, `MSB_FIRST`=1, one-cycle accept of 0xA5:
  - `ser_out` = 1,0,1,0,0,1,0,1 on 8 consecutive cycles;
  - `frame` high for those 8 cycles;
  - `done` high only on the 8th;
  - then `IDLE` with `ser_out`=0.
- `MSB_FIRST`=0, 0x01 → `ser_out` = 1 then seven 0s.
- Back-to-back 0xA5 then 0x3C with `load_valid` held:
  - `frame` high for 16 contiguous cycles;
  - second word begins the cycle after the first word's `done`;
  - exactly 2 accepts.
- `load_valid` asserted with 0xFF during bit 3 of 0x00 → not accepted until the last-bit cycle; 0x00's bits are unchanged.
- `rst` pulsed after 3 bits of 0xA5:
  - next cycle `frame`=0, `ser_out`=0, `done`=0, `load_ready`=1;
  - a subsequent 0x3C transmits correctly.
- `WIDTH`=1, continuous valid with alternating 1/0 → `ser_out` toggles every cycle; `done` and `frame` stay high.
